// File: rtl/instr_sequencer.sv
// instr_sequencer: mode-1 fetch/issue/commit controller between the PC/ROM block and the ALU.
// Optional build macro SEQ_TIMEOUT_EN adds an ALU-ack timeout with a sticky err flag.
`default_nettype none

module instr_sequencer #(
   parameter int TIMEOUT = 15
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ena,
   input  logic       resume,
   input  logic [7:0] instr_in,
   output logic       pc_step,
   output logic       alu_req,
   output logic [2:0] alu_op,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   input  logic       alu_ack,
   input  logic [7:0] alu_result,
   output logic [7:0] acc_out,
   output logic       busy,
   output logic       halted,
   output logic       err
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_ISSUE  = 3'd2,
      S_COMMIT = 3'd3,
      S_HALT   = 3'd4
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] ir_q, ir_d;
   logic [7:0] acc_q, acc_d;
   logic       is_alu_op;
   logic       is_halt_op;

`ifdef SEQ_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
   logic [7:0] wait_q, wait_d;
   logic       err_q, err_d;
`endif

   assign is_alu_op  = (ir_q[7:6] == 2'b00) || (ir_q[7:5] == 3'b010);
   assign is_halt_op = (ir_q[7:5] == 3'b111);

   // Request is decoded from registered state, so an async reset withdraws it at once.
   assign alu_req = (state_q == S_ISSUE) && is_alu_op;
   assign alu_op  = ir_q[7:5];
   assign alu_a   = acc_q;
   assign alu_b   = {3'b000, ir_q[4:0]};
   assign acc_out = acc_q;
   assign pc_step = (state_q == S_COMMIT);
   assign busy    = (state_q == S_FETCH) || (state_q == S_ISSUE) || (state_q == S_COMMIT);
   assign halted  = (state_q == S_HALT);

`ifdef SEQ_TIMEOUT_EN
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      acc_d   = acc_q;
`ifdef SEQ_TIMEOUT_EN
      wait_d  = wait_q;
      err_d   = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (ena) state_d = S_FETCH;
         end
         S_FETCH: begin
            ir_d    = instr_in;
            state_d = S_ISSUE;
`ifdef SEQ_TIMEOUT_EN
            wait_d  = 8'd0;
`endif
         end
         S_ISSUE: begin
            if (is_alu_op) begin
               if (alu_ack) begin
                  acc_d   = alu_result;
                  state_d = S_COMMIT;
               end
`ifdef SEQ_TIMEOUT_EN
               else if (wait_q == TIMEOUT_LAST) begin
                  err_d   = 1'b1;
                  state_d = S_COMMIT;
               end else begin
                  wait_d  = wait_q + 8'd1;
               end
`endif
            end else if (is_halt_op) begin
               state_d = S_HALT;
            end else begin
               state_d = S_COMMIT;
            end
         end
         S_COMMIT: begin
            state_d = ena ? S_FETCH : S_IDLE;
         end
         S_HALT: begin
            if (resume) state_d = S_COMMIT;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         ir_q    <= 8'd0;
         acc_q   <= 8'd0;
`ifdef SEQ_TIMEOUT_EN
         wait_q  <= 8'd0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         acc_q   <= acc_d;
`ifdef SEQ_TIMEOUT_EN
         wait_q  <= wait_d;
         err_q   <= err_d;
`endif
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer with a small PC/ROM and ALU model.
`default_nettype none

module tb_instr_sequencer;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       ena = 1'b0;
   logic       resume = 1'b0;
   logic [7:0] instr_in;
   logic       pc_step;
   logic       alu_req;
   logic [2:0] alu_op;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic       alu_ack;
   logic [7:0] alu_result;
   logic [7:0] acc_out;
   logic       busy;
   logic       halted;
   logic       err;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] rom [4];
   logic [1:0] pc;
   logic [7:0] req_cnt;
   logic [7:0] ack_delay = 8'd0;
   logic       never_ack = 1'b0;

   instr_sequencer #(.TIMEOUT(15)) dut (
      .clock      (clock),
      .reset      (reset),
      .ena        (ena),
      .resume     (resume),
      .instr_in   (instr_in),
      .pc_step    (pc_step),
      .alu_req    (alu_req),
      .alu_op     (alu_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_ack    (alu_ack),
      .alu_result (alu_result),
      .acc_out    (acc_out),
      .busy       (busy),
      .halted     (halted),
      .err        (err)
   );

   always #5 clock = ~clock;

   // PC block: wraps over a 4-word program.
   always @(posedge clock or posedge reset) begin
      if (reset)        pc <= 2'd0;
      else if (pc_step) pc <= pc + 2'd1;
   end
   assign instr_in = rom[pc];

   // ALU model: acks after ack_delay cycles of request.
   always @(posedge clock or posedge reset) begin
      if (reset)                     req_cnt <= 8'd0;
      else if (alu_req && !alu_ack)  req_cnt <= req_cnt + 8'd1;
      else                           req_cnt <= 8'd0;
   end
   assign alu_ack = alu_req && !never_ack && (req_cnt == ack_delay);
   always_comb begin
      alu_result = 8'd0;
      case (alu_op)
         3'b000:  alu_result = alu_a + alu_b;
         3'b001:  alu_result = alu_a - alu_b;
         3'b010:  alu_result = alu_a * alu_b;
         default: alu_result = 8'd0;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_step(input int budget, output int cycles);
      cycles = 0;
      do begin
         @(negedge clock);
         cycles++;
      end while (!pc_step && cycles < budget);
      check("pc_step_seen", {31'd0, pc_step}, 32'd1);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      ena   = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic load_basic();
      rom[0] = 8'h03;   // ADD 3
      rom[1] = 8'h22;   // SUB 2
      rom[2] = 8'h45;   // MUL 5
      rom[3] = 8'h00;   // ADD 0
   endtask

   initial begin
      int cyc;
      int steps;
      logic [7:0] exp_acc [6];
      exp_acc = '{8'd3, 8'd1, 8'd5, 8'd5, 8'd8, 8'd6};

      // Reset state
      load_basic();
      do_reset();
      check("rst_pc_step", {31'd0, pc_step}, 32'd0);
      check("rst_alu_req", {31'd0, alu_req}, 32'd0);
      check("rst_busy",    {31'd0, busy},    32'd0);
      check("rst_halted",  {31'd0, halted},  32'd0);
      check("rst_err",     {31'd0, err},     32'd0);
      check("rst_acc",     {24'd0, acc_out}, 32'd0);
      check("rst_alu_op",  {29'd0, alu_op},  32'd0);
      check("rst_alu_a",   {24'd0, alu_a},   32'd0);
      check("rst_alu_b",   {24'd0, alu_b},   32'd0);

      // Immediate ack: 3-cycle period, acc 3,1,5,5 then 8,6 after wrap
      ena = 1'b1;
      for (int i = 0; i < 6; i++) begin
         wait_step(10, cyc);
         check($sformatf("imm_acc%0d", i), {24'd0, acc_out}, {24'd0, exp_acc[i]});
         check($sformatf("imm_period%0d", i), cyc, 32'd3);
      end

      // Delayed ack by 4: 7-cycle period, request held 5 cycles with stable operands
      do_reset();
      ack_delay = 8'd4;
      ena = 1'b1;
      wait_step(12, cyc);
      check("dly_acc0", {24'd0, acc_out}, 32'd3);
      check("dly_period0", cyc, 32'd7);
      @(negedge clock);
      check("dly_fetch_noreq", {31'd0, alu_req}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check($sformatf("dly_req%0d", i), {31'd0, alu_req}, 32'd1);
         check($sformatf("dly_ops%0d", i), {13'd0, alu_op, alu_a, alu_b}, {13'd0, 3'd1, 8'd3, 8'd2});
      end
      @(negedge clock);
      check("dly_commit_step", {31'd0, pc_step}, 32'd1);
      check("dly_commit_noreq", {31'd0, alu_req}, 32'd0);
      check("dly_acc1", {24'd0, acc_out}, 32'd1);
      for (int i = 2; i < 4; i++) begin
         wait_step(12, cyc);
         check($sformatf("dly_acc%0d", i), {24'd0, acc_out}, {24'd0, exp_acc[i]});
         check($sformatf("dly_period%0d", i), cyc, 32'd7);
      end

      // HALT at PC 2: no steps for 20 cycles, resume gives one step then continues
      ack_delay = 8'd0;
      rom[2] = 8'hE0;
      rom[3] = 8'h45;
      do_reset();
      ena = 1'b1;
      wait_step(10, cyc);
      wait_step(10, cyc);
      check("hlt_acc_pre", {24'd0, acc_out}, 32'd1);
      repeat (3) @(negedge clock);
      check("hlt_halted", {31'd0, halted}, 32'd1);
      check("hlt_busy", {31'd0, busy}, 32'd0);
      steps = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (pc_step) steps++;
      end
      check("hlt_no_step", steps, 32'd0);
      check("hlt_still", {31'd0, halted}, 32'd1);
      resume = 1'b1;
      @(negedge clock);
      resume = 1'b0;
      check("hlt_resume_step", {31'd0, pc_step}, 32'd1);
      check("hlt_left", {31'd0, halted}, 32'd0);
      check("hlt_acc_kept", {24'd0, acc_out}, 32'd1);
      wait_step(10, cyc);
      check("hlt_next_acc", {24'd0, acc_out}, 32'd5);
      check("hlt_next_period", cyc, 32'd3);

      // ena drops during ISSUE of SUB 2
      load_basic();
      ack_delay = 8'd2;
      do_reset();
      ena = 1'b1;
      wait_step(12, cyc);
      check("ena_acc0", {24'd0, acc_out}, 32'd3);
      @(negedge clock);
      @(negedge clock);
      check("ena_issue_req", {31'd0, alu_req}, 32'd1);
      ena = 1'b0;
      wait_step(12, cyc);
      check("ena_acc1", {24'd0, acc_out}, 32'd1);
      @(negedge clock);
      check("ena_idle_busy", {31'd0, busy}, 32'd0);
      steps = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         if (pc_step || busy) steps++;
      end
      check("ena_idle_quiet", steps, 32'd0);
      ena = 1'b1;
      wait_step(12, cyc);
      check("ena_resume_acc", {24'd0, acc_out}, 32'd5);

      // Async reset while alu_req is high
      ack_delay = 8'd0;
      do_reset();
      ena = 1'b1;
      wait_step(10, cyc);
      @(negedge clock);
      never_ack = 1'b1;
      @(negedge clock);
      check("arst_req_before", {31'd0, alu_req}, 32'd1);
      #2 reset = 1'b1;
      #1;
      check("arst_req", {31'd0, alu_req}, 32'd0);
      check("arst_acc", {24'd0, acc_out}, 32'd0);
      check("arst_busy", {31'd0, busy}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      ena = 1'b0;

`ifdef SEQ_TIMEOUT_EN
      // Never-acked ADD 3 times out after 15 ISSUE cycles
      do_reset();
      never_ack = 1'b1;
      ena = 1'b1;
      wait_step(40, cyc);
      check("to_period", cyc, 32'd17);
      check("to_err", {31'd0, err}, 32'd1);
      check("to_req", {31'd0, alu_req}, 32'd0);
      check("to_acc", {24'd0, acc_out}, 32'd0);
      never_ack = 1'b0;
`else
      check("noto_err", {31'd0, err}, 32'd0);
      never_ack = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Mode-1 execution controller for the PC/ROM program path. Fetches the 8-bit instruction presented by the PC/ROM block and decodes it as opcode [7:5] and operand [4:0].
- Issues each ALU operation over a req/ack handshake and commits the result into an 8-bit accumulator. Pulses the PC's enable exactly once per retired instruction.
- Sits between the PC/ROM block and the ALU, under the top-level mode select.

Parameters:
- TIMEOUT, 15: maximum cycles alu_req may stay high without alu_ack. Used only with SEQ_TIMEOUT_EN. Range 1..255.

Ports:
- clock  input  1  system clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-high; clears all state
- ena  input  1  run enable from the top level (mode==1 and run)
- resume  input  1  single-cycle pulse; leaves HALT
- instr_in  input  8  instruction from PC/ROM at the current PC
- pc_step  output  1  one-cycle pulse; drives the PC block's ena
- alu_req  output  1  request; held high until ack
- alu_op  output  3  opcode to ALU (000 ADD, 001 SUB, 010 MUL)
- alu_a  output  8  current accumulator value
- alu_b  output  8  operand zero-extended: {3'b000, ir[4:0]}
- alu_ack  input  1  ALU result valid this cycle
- alu_result  input  8  ALU result, truncated to 8 bits by the ALU
- acc_out  output  8  accumulator
- busy  output  1  high in FETCH, ISSUE or COMMIT
- halted  output  1  high in HALT
- err  output  1  sticky timeout flag; constant 0 without SEQ_TIMEOUT_EN

Behaviour:
- Reset (async): state=IDLE; ir=0, acc_out=0. pc_step, alu_req, busy, halted and err are 0. alu_op, alu_a and alu_b are 0.
- States: IDLE, FETCH, ISSUE, COMMIT, HALT.
- IDLE:
  - ena=1 -> FETCH; otherwise stay.
- FETCH:
  - ir <= instr_in.
  - Always -> ISSUE.
- ISSUE, decode of ir[7:5]:
  - 000/001/010: alu_req=1 with alu_op/alu_a/alu_b stable. Stay in ISSUE while alu_ack=0.
  - On the edge where alu_req=1 and alu_ack=1: acc <= alu_result, -> COMMIT.
  - 111 (HALT): no request; -> HALT. PC is not stepped.
  - 011..110 (reserved): no request, acc unchanged; -> COMMIT.
- COMMIT:
  - pc_step=1 for this cycle only.
  - -> FETCH if ena=1, else -> IDLE.
- HALT:
  - halted=1; pc_step never asserts.
  - resume=1 -> COMMIT (steps past the HALT instruction).
- Latency:
  - ALU instruction with ack in the first ISSUE cycle: 3 cycles per instruction (FETCH, ISSUE, COMMIT).
  - Each extra ack wait adds 1 cycle.
  - Reserved opcodes always take 3 cycles.
- Arithmetic: acc takes alu_result verbatim; no saturation or flag generation in this block.
- Word 8'h00 decodes as ADD 0: an ALU transaction occurs and acc is unchanged.
- ena deasserted mid-instruction: the current instruction completes through COMMIT (pc_step still pulses), then -> IDLE. alu_req is never withdrawn before ack.
- ena=0 while in HALT: no effect; only resume or reset leaves HALT.
- resume outside HALT: ignored.
- alu_ack outside ISSUE, or while alu_req=0: ignored.
- Reset mid-transaction: alu_req drops immediately (asynchronously) and acc clears. The ALU discards any pending op.
- PC wrap-around is owned by the PC block. The sequencer only pulses pc_step and re-fetches whatever instr_in shows.

Optional Feature:
- Macro SEQ_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter clears on entry to ISSUE and increments each ISSUE cycle with alu_ack=0.
  - On reaching TIMEOUT: alu_req drops, err <= 1 (sticky until reset), acc unchanged, -> COMMIT (instruction skipped).
- Undefined: the counter is not built, err is tied to 0, and the sequencer waits for ack indefinitely.

Test Plan:
- Program ADD 3, SUB 2, MUL 5, 8'h00; ALU model acks immediately; ena=1.
  - acc sequence: 3, 1, 5, 5.
  - pc_step pulses every 3 cycles.
  - After wrap: acc=8, then 6.
- Same program with ALU ack delayed 4 cycles.
  - alu_req stays high 5 cycles with stable alu_op/alu_a/alu_b.
  - Instruction period is 7 cycles; final acc values are identical to the immediate-ack case.
- Instruction 8'hE0 (HALT) at PC 2.
  - halted=1 and no pc_step for 20 cycles.
  - A resume pulse yields one pc_step, then execution continues.
- ena drops during ISSUE of SUB 2 (acc=3).
  - Ack completes, acc=1, one pc_step, then IDLE with busy=0.
  - Re-raising ena fetches the next instruction.
- Reset asserted while alu_req=1.
  - Same-cycle: alu_req=0, acc_out=0, state IDLE, with no clock edge needed.
- With SEQ_TIMEOUT_EN, TIMEOUT=15, ALU never acks ADD 3.
  - After 15 ISSUE cycles: alu_req drops, err=1, one pc_step, acc=0.
